// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state;
  logic [PRESC_WIDTH-1:0]  edge_cnt;
  logic [BCW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]   data_sr;
  logic                    par_en_q;
  logic                    par_bit;
  logic [PRESC_WIDTH-1:0]  p_last;
  logic                    bit_end;
  logic                    stop_end;
  logic                    accept;

  // Prescale values below 4 clamp to 4; ">=" keeps a mid-bit prescale drop from locking up.
  assign p_last  = (prescale < PRESC_WIDTH'(4)) ? PRESC_WIDTH'(3) : prescale - PRESC_WIDTH'(1);
  assign bit_end = (edge_cnt >= p_last);

`ifdef UART_TX_TWO_STOP_EN
  logic stop_second;
  assign stop_end = bit_end && stop_second;
`else
  assign stop_end = bit_end;
`endif

  // Handshake: DATA_VALID is a one-cycle strobe with an implicit ready of
  // (IDLE) or (last cycle of the final stop bit); a strobe outside that window is dropped.
  assign accept = DATA_VALID && ((state == S_IDLE) || ((state == S_STOP) && stop_end));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      data_sr  <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_second <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          TX_OUT   <= 1'b1;
          busy     <= 1'b0;
          edge_cnt <= '0;
        end
        S_START: begin
          if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
            TX_OUT   <= data_sr[0];
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                state  <= S_PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= S_STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              data_sr <= data_sr >> 1;
              TX_OUT  <= data_sr[1];
            end
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            edge_cnt <= '0;
            state    <= S_STOP;
            TX_OUT   <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        S_STOP: begin
          TX_OUT <= 1'b1;
          if (bit_end) begin
            edge_cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
            if (!stop_second) begin
              stop_second <= 1'b1;
            end else begin
              stop_second <= 1'b0;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          TX_OUT   <= 1'b1;
          busy     <= 1'b0;
          edge_cnt <= '0;
        end
      endcase

      // A new frame overrides whatever the case above chose (IDLE or end of STOP).
      if (accept) begin
        data_sr  <= P_DATA;
        par_en_q <= PAR_EN;
        par_bit  <= (^P_DATA) ^ PAR_TYP;
        state    <= S_START;
        TX_OUT   <= 1'b0;
        busy     <= 1'b1;
        edge_cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
        stop_second <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: table of frames plus back-to-back and mid-frame reset sequences.
// Honours UART_TX_TWO_STOP_EN for the expected stop-bit count.
module tb_uart_tx_fsm;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int NVEC = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // body = {parity, data[7:0], start}; bit i is the i-th transmitted bit, stop bits follow.
  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic [5:0] presc;
    int         p_eff;
    int         nbits;
    logic [9:0] body;
    int         inj;
  } frame_t;

  frame_t vecs [NVEC];

  uart_tx_fsm #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .prescale   (prescale),
    .TX_OUT     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic begin_frame(input frame_t f);
    @(negedge clk);
    prescale   = f.presc;
    p_data     = f.data;
    par_en     = f.par_en;
    par_typ    = f.par_typ;
    data_valid = 1'b1;
  endtask

  // Expects the strobe for f to be on the inputs; optionally strobes nx in the last stop cycle.
  task automatic check_frame(input int id, input frame_t f, input bit chain, input frame_t nx);
    int   total;
    int   busy_cnt;
    int   c;
    int   hits;
    logic expb;
    total    = (f.nbits + STOPS) * f.p_eff;
    busy_cnt = 0;
    c        = 0;
    @(posedge clk);
    for (int b = 0; b < f.nbits + STOPS; b++) begin
      expb = (b < f.nbits) ? f.body[b] : 1'b1;
      hits = 0;
      for (int k = 0; k < f.p_eff; k++) begin
        @(negedge clk);
        if (tx_out === expb) hits++;
        if (busy === 1'b1) busy_cnt++;
        data_valid = 1'b0;
        p_data     = 8'($urandom_range(0, 255));
        par_en     = 1'($urandom_range(0, 1));
        par_typ    = 1'($urandom_range(0, 1));
        if (c == f.inj) begin
          data_valid = 1'b1;
          p_data     = 8'hFF;
        end
        if (chain && c == total - 1) begin
          data_valid = 1'b1;
          p_data     = nx.data;
          par_en     = nx.par_en;
          par_typ    = nx.par_typ;
        end
        c++;
      end
      check($sformatf("f%0d_bit%0d_cycles", id, b), hits, f.p_eff);
    end
    check($sformatf("f%0d_busy_cycles", id), busy_cnt, total);
    if (!chain) begin
      @(negedge clk);
      check($sformatf("f%0d_idle_tx", id), tx_out, 1);
      check($sformatf("f%0d_idle_busy", id), busy, 0);
    end
  endtask

  initial begin
    frame_t a;
    frame_t b;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  8,  9, 10'b0_10100101_0, -1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd16, 16, 10, 10'b0_10100101_0, -1};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd16, 16, 10, 10'b1_10100101_0, -1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 6'd8,  8,  9, 10'b0_00000000_0, 40};
    vecs[4] = '{8'h01, 1'b0, 1'b0, 6'd2,  4,  9, 10'b0_00000001_0, -1};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 6'd5,  5, 10, 10'b1_01010101_0, -1};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 6'd63, 63, 10, 10'b0_11111111_0, -1};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 6'd0,  4, 10, 10'b1_10000000_0, -1};
    vecs[8] = '{8'h5A, 1'b1, 1'b1, 6'd3,  4, 10, 10'b1_01011010_0, 5};

    repeat (2) @(negedge clk);
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", tx_out, 1);
    check("idle_busy", busy, 0);

    for (int i = 0; i < NVEC; i++) begin
      begin_frame(vecs[i]);
      check_frame(i, vecs[i], 1'b0, vecs[i]);
    end

    // Back-to-back: 0xC3 strobed in the last stop cycle of 0x3C.
    a = '{8'h3C, 1'b0, 1'b0, 6'd8, 8, 9, 10'b0_00111100_0, -1};
    b = '{8'hC3, 1'b0, 1'b0, 6'd8, 8, 9, 10'b0_11000011_0, -1};
    begin_frame(a);
    check_frame(20, a, 1'b1, b);
    check_frame(21, b, 1'b0, b);

    // Reset during data bit 3 of a 0x00 frame.
    a = '{8'h00, 1'b0, 1'b0, 6'd8, 8, 9, 10'b0_00000000_0, -1};
    begin_frame(a);
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("pre_rst_tx", tx_out, 0);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx_out, 1);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_tx", tx_out, 1);
    check("post_rst_busy", busy, 0);
    b = '{8'h55, 1'b0, 1'b0, 6'd8, 8, 9, 10'b0_01010101_0, -1};
    begin_frame(b);
    check_frame(30, b, 1'b0, b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
UART transmitter: accepts a parallel byte with a one-cycle valid strobe and serialises it onto TX_OUT.
- Frame order: start bit, data LSB first, optional parity bit, stop bit.
- Runs on the same oversampled clock as the receive path; each bit is held for `prescale` CLK cycles.
- Pairs with the RX chain on the opposite end of the serial link.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESC_WIDTH, 6, width of the prescale input

Ports:
CLK  input  1  oversampled clock (prescale cycles per bit)
RST  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel byte to send
DATA_VALID  input  1  P_DATA valid strobe; accepted only when ready (see Behaviour)
PAR_EN  input  1  1 = parity bit inserted
PAR_TYP  input  1  0 = even parity, 1 = odd parity
prescale  input  PRESC_WIDTH  CLK cycles per bit; legal 4..63; values 0..3 treated as 4
TX_OUT  output  1  serial line, registered, idle high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (async, RST=1): state IDLE, TX_OUT=1, busy=0, counters=0, shift/parity registers=0. Takes effect immediately, including mid-frame.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit timing:
  - Edge counter counts 0..P-1, where P = max(prescale,4).
  - Bit ends when edge_cnt==P-1; edge_cnt then wraps to 0.
  - Bit counter tracks data bits 0..DATA_WIDTH-1.
- Accept condition: DATA_VALID=1 and (state==IDLE, or state==STOP with edge_cnt==P-1).
  - On accept, latch P_DATA, PAR_EN and PAR_TYP, and compute parity = XOR(P_DATA) ^ PAR_TYP.
  - Latched values are frozen for the whole frame. Input changes mid-frame have no effect.
  - DATA_VALID while not accepting is dropped; no queueing.
- IDLE -> START on accept. TX_OUT=0 and busy=1 from the next CLK edge (latency 1 cycle).
- START: hold 0 for P cycles, then go to DATA with bit 0.
- DATA: TX_OUT = latched bit[bit_cnt], each held P cycles. After bit DATA_WIDTH-1 ends, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = parity bit for P cycles, then go to STOP.
- STOP: TX_OUT=1 for P cycles.
  - At the end of STOP: if accept, go to START with no idle gap (back-to-back frames).
  - Otherwise go to IDLE; busy drops on the same edge that enters IDLE.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) * P cycles.
- prescale is sampled every cycle, but the team requires it static while busy. A mid-frame change affects only the current bit's terminal count. No lock-up: edge_cnt >= P-1 also ends the bit.
- TX_OUT and busy are registered; no combinational path from inputs to outputs.
- Unused state encodings return to IDLE with TX_OUT=1.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: STOP lasts 2*P cycles (two stop bits). The accept window moves to the last cycle of the second stop bit. Frame length grows by P.
- Undefined: a single stop bit, as described in Behaviour.

Test Plan:
1. Basic frame: prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID in IDLE -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. busy high for exactly 80 cycles, starting the cycle after the strobe.
2. Parity: prescale=16, PAR_EN=1, P_DATA=0xA5. PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1. Frame = 11 bits = 176 cycles.
3. Back-to-back: prescale=8, send 0x3C, then assert DATA_VALID with 0xC3 in the last STOP cycle -> the start bit of 0xC3 immediately follows the stop bit of 0x3C. busy never drops between frames.
4. Ignore-while-busy: DATA_VALID=1 with 0xFF in mid-DATA of a 0x00 frame -> 0x00 frame unchanged, 0xFF never sent, busy falls after 80 cycles.
5. Reset mid-frame: RST=1 during DATA bit 3 -> TX_OUT=1 and busy=0 asynchronously. After release, the next DATA_VALID with 0x55 produces a clean full frame.
6. Prescale clamp: prescale=2, P_DATA=0x01 -> every bit lasts 4 cycles; frame = 40 cycles.
